dma_handshake_monitor: RTL and testbench

- Synthesizable, parametrised DMA handshake monitor and checker. It generalises the per-channel DREQ/DACK/IOR/IOW coverage points to NUM_CH channels.
- Adds per-channel protocol state tracking, error detection with codes, request-timeout checking, sticky coverage bits and grant counters.
- Sits beside the DMA controller on the bus interface signals. It is passive and never drives the bus.

---
 rtl/dma_mon_pkg.sv | 43 ++++
 rtl/dma_ch_monitor.sv | 132 +++++++++++++
 rtl/dma_handshake_monitor.sv | 116 +++++++++++
 tb/tb_dma_handshake_monitor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_mon_pkg.sv
// Shared types, constants and small helpers for the DMA handshake monitor.
// The MON_GRANT_CNT_EN build option is consumed by dma_ch_monitor.
package dma_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_TOUT = 2'd3
    } ch_state_e;

    localparam int NUM_ERR    = 4;
    localparam int ERR_CODE_W = 2;

    typedef enum logic [ERR_CODE_W-1:0] {
        ERR_RW_CONFLICT = 2'd0,
        ERR_TIMEOUT     = 2'd1,
        ERR_ACK_NO_REQ  = 2'd2,
        ERR_MULTI_ACK   = 2'd3
    } err_code_e;

    function automatic logic [3:0] pop8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_ch_monitor.sv
// One DMA channel: handshake FSM, request wait counter, per-channel error flags
// and grant counter (grant counter built only when MON_GRANT_CNT_EN is defined).
module dma_ch_monitor
    import dma_mon_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_dreq,
    input  logic             i_dack,
    output logic             o_err_tout,
    output logic             o_err_anr,
    output logic [CNT_W-1:0] o_grant_cnt
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    ch_state_e         r_state;
    ch_state_e         w_state_next;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    logic              w_enter_ack;
    logic              w_err_tout;
    logic              w_err_anr;

    // State and wait counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_wait  <= {WAIT_W{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
        end
    end

    // Next-state, wait counting and per-channel error detection.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_enter_ack  = 1'b0;
        w_err_tout   = 1'b0;
        w_err_anr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_dack) begin
                    w_state_next = ST_ACK;
                    w_enter_ack  = 1'b1;
                    w_err_anr    = ~i_dreq;
                end else if (i_dreq) begin
                    w_state_next = ST_REQ;
                    w_wait_next  = WAIT_ONE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_dack) begin
                    w_state_next = ST_ACK;
                    w_enter_ack  = 1'b1;
                end else if (!i_dreq) begin
                    w_state_next = ST_IDLE;
                end else if (r_wait >= (WAIT_MAX - WAIT_ONE)) begin
                    // This sample is the TIMEOUT-th consecutive wait.
                    w_wait_next  = WAIT_MAX;
                    w_err_tout   = 1'b1;
                    w_state_next = ST_TOUT;
                end else begin
                    w_wait_next  = r_wait + WAIT_ONE;
                end
            end
            ST_TOUT: begin
                if (i_dack) begin
                    w_state_next = ST_ACK;
                    w_enter_ack  = 1'b1;
                end else if (!i_dreq) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_TOUT;
                end
            end
            ST_ACK: begin
                if (!i_dack) begin
                    if (i_dreq) begin
                        w_state_next = ST_REQ;
                        w_wait_next  = WAIT_ONE;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_ACK;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_wait_next  = {WAIT_W{1'b0}};
            end
        endcase
    end

    assign o_err_tout = w_err_tout;
    assign o_err_anr  = w_err_anr;

`ifdef MON_GRANT_CNT_EN
    logic [CNT_W-1:0] r_grant_cnt;

    // Saturating grant counter; a grant in the clearing sample still counts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_grant_cnt <= w_enter_ack ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (w_enter_ack && (r_grant_cnt != {CNT_W{1'b1}})) begin
            r_grant_cnt <= r_grant_cnt + CNT_W'(1);
        end else begin
            r_grant_cnt <= r_grant_cnt;
        end
    end

    assign o_grant_cnt = r_grant_cnt;
`else
    logic w_unused;
    assign w_unused    = i_clr ^ w_enter_ack;
    assign o_grant_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: rtl/dma_handshake_monitor.sv
// Passive DMA handshake checker: per-channel monitors plus error priority,
// sticky error/coverage state. Grant counters exist only with MON_GRANT_CNT_EN.
module dma_handshake_monitor
    import dma_mon_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_CH-1:0]       DREQ,
    input  logic [NUM_CH-1:0]       DACK,
    input  logic                    IOR,
    input  logic                    IOW,
    input  logic                    clr,
    output logic                    err_valid,
    output logic [ERR_CODE_W-1:0]   err_code,
    output logic [2:0]              err_ch,
    output logic [NUM_ERR-1:0]      err_sticky,
    output logic [2*NUM_CH+1:0]     cover_hit,
    output logic [NUM_CH*CNT_W-1:0] grant_cnt
);

    localparam int COV_W = 2 * NUM_CH + 2;

    logic [NUM_CH-1:0]  w_tout;
    logic [NUM_CH-1:0]  w_anr;
    logic [7:0]         w_dack8;
    logic [7:0]         w_tout8;
    logic [7:0]         w_anr8;
    logic               w_multi;
    logic               w_rw;
    logic [NUM_ERR-1:0] w_err_vec;
    err_code_e          w_code;
    logic [2:0]         w_ch;
    logic [COV_W-1:0]   w_cov_hit;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            localparam logic [NUM_CH-1:0] ONEHOT = NUM_CH'(1) << g;

            dma_ch_monitor #(
                .TIMEOUT (TIMEOUT),
                .CNT_W   (CNT_W)
            ) u_ch (
                .i_clk       (CLK),
                .i_rst       (RESET),
                .i_clr       (clr),
                .i_dreq      (DREQ[g]),
                .i_dack      (DACK[g]),
                .o_err_tout  (w_tout[g]),
                .o_err_anr   (w_anr[g]),
                .o_grant_cnt (grant_cnt[g*CNT_W +: CNT_W])
            );

            assign w_cov_hit[g]          = (DREQ == ONEHOT);
            assign w_cov_hit[NUM_CH + g] = (DACK == ONEHOT);
        end
    endgenerate

    assign w_cov_hit[2*NUM_CH]     = IOR;
    assign w_cov_hit[2*NUM_CH + 1] = IOW;

    // Widen channel vectors to the fixed 8-bit helper width.
    always_comb begin
        w_dack8 = 8'd0;
        w_tout8 = 8'd0;
        w_anr8  = 8'd0;
        w_dack8[NUM_CH-1:0] = DACK;
        w_tout8[NUM_CH-1:0] = w_tout;
        w_anr8[NUM_CH-1:0]  = w_anr;
    end

    assign w_multi   = (pop8(w_dack8) > 4'd1);
    assign w_rw      = IOR & IOW;
    assign w_err_vec = {w_multi, |w_anr, |w_tout, w_rw};

    // Report the highest-priority error, then its lowest channel.
    always_comb begin
        w_code = ERR_RW_CONFLICT;
        w_ch   = 3'd0;
        if (w_multi) begin
            w_code = ERR_MULTI_ACK;
            w_ch   = lowest8(w_dack8);
        end else if (|w_anr) begin
            w_code = ERR_ACK_NO_REQ;
            w_ch   = lowest8(w_anr8);
        end else if (|w_tout) begin
            w_code = ERR_TIMEOUT;
            w_ch   = lowest8(w_tout8);
        end else begin
            w_code = ERR_RW_CONFLICT;
            w_ch   = 3'd0;
        end
    end

    // Registered error report and sticky state; new events win over clr.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_valid  <= 1'b0;
            err_code   <= {ERR_CODE_W{1'b0}};
            err_ch     <= 3'd0;
            err_sticky <= {NUM_ERR{1'b0}};
            cover_hit  <= {COV_W{1'b0}};
        end else begin
            err_valid  <= |w_err_vec;
            err_code   <= w_code;
            err_ch     <= w_ch;
            err_sticky <= (clr ? {NUM_ERR{1'b0}} : err_sticky) | w_err_vec;
            cover_hit  <= (clr ? {COV_W{1'b0}} : cover_hit) | w_cov_hit;
        end
    end

endmodule

// File: tb/tb_dma_handshake_monitor.sv
// Randomized and directed bench for dma_handshake_monitor, checked against a
// sample-history model of the handshake rules.
module tb_dma_handshake_monitor;

    localparam int NCH   = 4;
    localparam int TOUTN = 16;
    localparam int CW    = 2;
`ifdef MON_GRANT_CNT_EN
    localparam int GC_EN = 1;
`else
    localparam int GC_EN = 0;
`endif

    logic            CLK = 1'b0;
    logic            RESET = 1'b0;
    logic [NCH-1:0]  DREQ = '0;
    logic [NCH-1:0]  DACK = '0;
    logic            IOR = 1'b0;
    logic            IOW = 1'b0;
    logic            clr = 1'b0;
    logic            err_valid;
    logic [1:0]      err_code;
    logic [2:0]      err_ch;
    logic [3:0]      err_sticky;
    logic [2*NCH+1:0] cover_hit;
    logic [NCH*CW-1:0] grant_cnt;

    dma_handshake_monitor #(.NUM_CH(NCH), .TIMEOUT(TOUTN), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .DACK(DACK), .IOR(IOR), .IOW(IOW),
        .clr(clr), .err_valid(err_valid), .err_code(err_code), .err_ch(err_ch),
        .err_sticky(err_sticky), .cover_hit(cover_hit), .grant_cnt(grant_cnt)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: previous sample per channel, length of the current
    // request-without-ack run, and grant totals.
    int run [NCH];
    bit pq  [NCH];
    bit pk  [NCH];
    int gcnt[NCH];
    logic             exp_valid = 1'b0;
    logic [1:0]       exp_code = 2'd0;
    logic [2:0]       exp_ch = 3'd0;
    logic [3:0]       exp_sticky = 4'd0;
    logic [2*NCH+1:0] exp_cover = '0;
    logic [NCH*CW-1:0] exp_grant = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int first_set(input logic [NCH-1:0] v);
        int r = 0;
        for (int i = NCH - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_step();
        logic rw, multi;
        logic [NCH-1:0] anr, tout;
        int cmax;
        cmax = (1 << CW) - 1;
        if (RESET) begin
            for (int c = 0; c < NCH; c++) begin
                run[c] = 0; pq[c] = 1'b0; pk[c] = 1'b0; gcnt[c] = 0;
            end
            exp_valid = 1'b0; exp_code = 2'd0; exp_ch = 3'd0;
            exp_sticky = 4'd0; exp_cover = '0; exp_grant = '0;
            return;
        end
        rw = IOR & IOW;
        multi = ($countones(DACK) > 1);
        for (int c = 0; c < NCH; c++) begin
            // A channel is idle when the previous sample showed neither DREQ nor DACK.
            anr[c] = DACK[c] && !DREQ[c] && !pq[c] && !pk[c];
            if (DREQ[c] && !DACK[c]) run[c]++;
            else run[c] = 0;
            tout[c] = (run[c] == TOUTN);
            if (clr) gcnt[c] = 0;
            if (DACK[c] && !pk[c] && gcnt[c] < cmax) gcnt[c]++;
            pq[c] = DREQ[c];
            pk[c] = DACK[c];
        end
        exp_valid = rw | multi | (|anr) | (|tout);
        if (multi) begin
            exp_code = 2'd3; exp_ch = 3'(first_set(DACK));
        end else if (|anr) begin
            exp_code = 2'd2; exp_ch = 3'(first_set(anr));
        end else if (|tout) begin
            exp_code = 2'd1; exp_ch = 3'(first_set(tout));
        end else begin
            exp_code = 2'd0; exp_ch = 3'd0;
        end
        exp_sticky = (clr ? 4'd0 : exp_sticky) | {multi, |anr, |tout, rw};
        if (clr) exp_cover = '0;
        for (int c = 0; c < NCH; c++) begin
            if (DREQ == (NCH'(1) << c)) exp_cover[c] = 1'b1;
            if (DACK == (NCH'(1) << c)) exp_cover[NCH + c] = 1'b1;
            exp_grant[c*CW +: CW] = (GC_EN != 0) ? CW'(gcnt[c]) : CW'(0);
        end
        if (IOR) exp_cover[2*NCH] = 1'b1;
        if (IOW) exp_cover[2*NCH+1] = 1'b1;
    endtask

    task automatic drive(input logic rst, input logic [NCH-1:0] rq, input logic [NCH-1:0] ak,
                         input logic r, input logic w, input logic c);
        @(negedge CLK);
        RESET = rst; DREQ = rq; DACK = ak; IOR = r; IOW = w; clr = c;
        model_step();
    endtask

    task automatic after_edge();
        @(posedge CLK);
        #3;
    endtask

    task automatic do_reset();
        drive(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Per-cycle comparison against the model.
    always @(posedge CLK) begin
        #2;
        if (chk_en) begin
            chk("err_valid", 64'(err_valid), 64'(exp_valid));
            if (exp_valid) begin
                chk("err_code", 64'(err_code), 64'(exp_code));
                chk("err_ch", 64'(err_ch), 64'(exp_ch));
            end
            chk("err_sticky", 64'(err_sticky), 64'(exp_sticky));
            chk("cover_hit", 64'(cover_hit), 64'(exp_cover));
            chk("grant_cnt", 64'(grant_cnt), 64'(exp_grant));
        end
    end

    initial begin
        logic [NCH-1:0] rq_st;
        logic [NCH-1:0] ak;
        int r;

        // Reset state
        do_reset();
        chk_en = 1'b1;
        do_reset();
        after_edge();
        chk("rst_valid", 64'(err_valid), 64'd0);
        chk("rst_sticky", 64'(err_sticky), 64'd0);
        chk("rst_cover", 64'(cover_hit), 64'd0);
        chk("rst_grant", 64'(grant_cnt), 64'd0);

        // Normal handshake on channel 1
        drive(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("hs_valid", 64'(err_valid), 64'd0);
        chk("hs_cover", 64'(cover_hit), 64'b00_0010_0010);
        chk("hs_grant1", 64'(grant_cnt[1*CW +: CW]), 64'(GC_EN));
        chk("hs_sticky", 64'(err_sticky), 64'd0);

        // Timeout on channel 0
        do_reset();
        repeat (16) drive(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("to_valid", 64'(err_valid), 64'd1);
        chk("to_code", 64'(err_code), 64'd1);
        chk("to_ch", 64'(err_ch), 64'd0);
        chk("to_sticky", 64'(err_sticky), 64'b0010);
        chk("to_model_sticky", 64'(exp_sticky), 64'b0010);
        repeat (4) begin
            drive(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
            after_edge();
            chk("to_no_repeat", 64'(err_valid), 64'd0);
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Ack without request on channel 2
        do_reset();
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("anr_valid", 64'(err_valid), 64'd1);
        chk("anr_code", 64'(err_code), 64'd2);
        chk("anr_ch", 64'(err_ch), 64'd2);
        chk("anr_grant2", 64'(grant_cnt[2*CW +: CW]), 64'(GC_EN));
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Simultaneous errors
        do_reset();
        drive(1'b0, 4'b0000, 4'b1010, 1'b1, 1'b1, 1'b0);
        after_edge();
        chk("sim_code", 64'(err_code), 64'd3);
        chk("sim_ch", 64'(err_ch), 64'd1);
        chk("sim_sticky", 64'(err_sticky), 64'b1101);
        chk("sim_model_code", 64'(exp_code), 64'd3);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Counter saturation, then clr while channels 2/3 are waiting
        do_reset();
        repeat (5) begin
            drive(1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("sat_grant3", 64'(grant_cnt[3*CW +: CW]), 64'(GC_EN != 0 ? 3 : 0));
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 4'b1100, 4'b0000, 1'b0, 1'b0, (i == 5) ? 1'b1 : 1'b0);
            if (i == 5) begin
                after_edge();
                chk("clr_grant", 64'(grant_cnt), 64'd0);
                chk("clr_cover", 64'(cover_hit), 64'd0);
                chk("clr_sticky", 64'(err_sticky), 64'd0);
            end
        end
        after_edge();
        chk("clr_fsm_tout", 64'(err_valid), 64'd1);
        chk("clr_fsm_ch", 64'(err_ch), 64'd2);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a request
        do_reset();
        repeat (10) drive(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (15) drive(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("mid_rst_sticky", 64'(err_sticky), 64'd0);
        chk("mid_rst_valid", 64'(err_valid), 64'd0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with periodic ack-free windows
        rq_st = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 7) == 0) rq_st[c] = ~rq_st[c];
            r = int'($urandom_range(0, 15));
            if ((i % 500) < 40 || r < 6) ak = '0;
            else if (r < 13) ak = NCH'(1) << $urandom_range(0, NCH - 1);
            else ak = NCH'($urandom_range(0, 15));
            drive(($urandom_range(0, 255) == 0) ? 1'b1 : 1'b0, rq_st, ak,
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        after_edge();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
